// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the shared single-port data memory: core (m0) has fixed
// priority, a starvation counter guarantees debug/DMA (m1) progress, m1 may lock.
module dmem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  m1_lock,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // Counter is 4 bits wide, so the limit must stay within 1..15.
    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    lock_state_e state_r;
    lock_state_e state_nxt_s;
    logic [3:0]  starve_cnt_r;
    logic [3:0]  starve_cnt_nxt_s;
    logic        m0_gnt_s;
    logic        m1_gnt_s;

    // Grant decision; grants are forced low while reset is asserted.
    always_comb begin
        m0_gnt_s = 1'b0;
        m1_gnt_s = 1'b0;
        if (!rst_n) begin
            m0_gnt_s = 1'b0;
            m1_gnt_s = 1'b0;
        end else if (state_r == LOCKED) begin
            m1_gnt_s = m1_req;
        end else if (m0_req && m1_req) begin
            if (starve_cnt_r == LIMIT_C) begin
                m1_gnt_s = 1'b1;
            end else begin
                m0_gnt_s = 1'b1;
            end
        end else if (m0_req) begin
            m0_gnt_s = 1'b1;
        end else if (m1_req) begin
            m1_gnt_s = 1'b1;
        end else begin
            m0_gnt_s = 1'b0;
            m1_gnt_s = 1'b0;
        end
    end

    assign m0_gnt = m0_gnt_s;
    assign m1_gnt = m1_gnt_s;

    // Memory-side mux; an idle bus drives all zeros.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (m1_gnt_s) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end else if (m0_gnt_s) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else begin
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    // Lock FSM next state: m1 keeps ownership until it drops lock, even when idle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            UNLOCKED: begin
                if (m1_gnt_s && m1_lock) begin
                    state_nxt_s = LOCKED;
                end else begin
                    state_nxt_s = UNLOCKED;
                end
            end
            LOCKED: begin
                if (!m1_lock) begin
                    state_nxt_s = UNLOCKED;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: state_nxt_s = UNLOCKED;
        endcase
    end

    // Starvation counter next value: saturating count of denied m1 cycles.
    always_comb begin
        starve_cnt_nxt_s = 4'd0;
        if (m1_req && !m1_gnt_s) begin
            if (starve_cnt_r == LIMIT_C) begin
                starve_cnt_nxt_s = starve_cnt_r;
            end else begin
                starve_cnt_nxt_s = starve_cnt_r + 4'd1;
            end
        end else begin
            starve_cnt_nxt_s = 4'd0;
        end
    end

    // Lock state and starvation counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= UNLOCKED;
            starve_cnt_r <= 4'd0;
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_cnt_nxt_s;
        end
    end

    // Master 0 read response: valid for one cycle after a granted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rvalid <= 1'b0;
            m0_rdata  <= '0;
        end else if (m0_gnt_s && !m0_we) begin
            m0_rvalid <= 1'b1;
            m0_rdata  <= mem_rdata;
        end else begin
            m0_rvalid <= 1'b0;
        end
    end

    // Master 1 read response: valid for one cycle after a granted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_rvalid <= 1'b0;
            m1_rdata  <= '0;
        end else if (m1_gnt_s && !m1_we) begin
            m1_rvalid <= 1'b1;
            m1_rdata  <= mem_rdata;
        end else begin
            m1_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory attached.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] tb_mem [0:255];
    int vectors = 0;
    int miscompares = 0;

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: synchronous write, combinational read.
    always @(posedge clk) if (mem_we) tb_mem[mem_addr[7:0]] <= mem_wdata;
    assign mem_rdata = tb_mem[mem_addr[7:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 256; k++) tb_mem[k] = 32'h0;
        tb_mem[8'h20] = 32'h1234_5678;
        rst_n = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hDEAD_BEEF;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10; m1_wdata = 32'h0; m1_lock = 1'b0;

        // Reset held with both masters requesting
        #12;
        chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        chk("rst_starve", 32'(dut.starve_cnt_r), 32'd0);

        // Release: m0 granted in the same cycle, writing DEADBEEF to 0x10
        rst_n = 1'b1;
        #1;
        chk("wr_m0_gnt", 32'(m0_gnt), 32'd1);
        chk("wr_m1_gnt", 32'(m1_gnt), 32'd0);
        chk("wr_mem_we", 32'(mem_we), 32'd1);
        chk("wr_mem_addr", mem_addr, 32'h10);
        chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick;

        // m0 reads 0x10
        m0_we = 1'b0; m1_req = 1'b0;
        #1;
        chk("rd_m0_gnt", 32'(m0_gnt), 32'd1);
        chk("rd_mem_we", 32'(mem_we), 32'd0);
        chk("rd_mem_addr", mem_addr, 32'h10);
        chk("rd_m0_rvalid_before", 32'(m0_rvalid), 32'd0);
        tick;
        m0_req = 1'b0;
        #1;
        chk("rd_m0_rvalid", 32'(m0_rvalid), 32'd1);
        chk("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);

        // Idle bus
        chk("idle_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("idle_mem_we", 32'(mem_we), 32'd0);
        chk("idle_mem_addr", mem_addr, 32'h0);
        chk("idle_mem_wdata", mem_wdata, 32'h0);
        chk("idle_starve", 32'(dut.starve_cnt_r), 32'd0);
        tick;
        #1;
        chk("idle_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("idle_m0_rdata_hold", m0_rdata, 32'hDEAD_BEEF);

        // Contention: pattern m0,m0,m0,m0,m1 repeating
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("cont_m0_gnt_%0d", i), 32'(m0_gnt), (i % 5 != 4) ? 32'd1 : 32'd0);
            chk($sformatf("cont_m1_gnt_%0d", i), 32'(m1_gnt), (i % 5 == 4) ? 32'd1 : 32'd0);
            chk($sformatf("cont_starve_%0d", i), 32'(dut.starve_cnt_r), 32'(i % 5));
            chk($sformatf("cont_m0_rvalid_%0d", i), 32'(m0_rvalid),
                (i > 0 && i % 5 != 0) ? 32'd1 : 32'd0);
            chk($sformatf("cont_m1_rvalid_%0d", i), 32'(m1_rvalid),
                (i > 0 && i % 5 == 0) ? 32'd1 : 32'd0);
            tick;
        end
        #1;
        chk("cont_m1_rvalid_end", 32'(m1_rvalid), 32'd1);
        chk("cont_m1_rdata_end", m1_rdata, 32'hDEAD_BEEF);
        chk("cont_starve_end", 32'(dut.starve_cnt_r), 32'd0);

        // Lock: m1 locked read of 0x20, won by starvation while m0 requests
        m1_addr = 32'h20; m1_lock = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk($sformatf("lk_wait_m0_gnt_%0d", j), 32'(m0_gnt), 32'd1);
            chk($sformatf("lk_wait_m1_gnt_%0d", j), 32'(m1_gnt), 32'd0);
            tick;
        end
        #1;
        chk("lk_m1_gnt", 32'(m1_gnt), 32'd1);
        chk("lk_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("lk_mem_addr", mem_addr, 32'h20);
        tick;
        m1_req = 1'b0;
        #1;
        chk("lk_idle_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("lk_idle_m1_gnt", 32'(m1_gnt), 32'd0);
        chk("lk_idle_mem_we", 32'(mem_we), 32'd0);
        chk("lk_m1_rvalid", 32'(m1_rvalid), 32'd1);
        chk("lk_m1_rdata", m1_rdata, 32'h1234_5678);
        tick;
        m1_req = 1'b1; m1_we = 1'b1; m1_wdata = 32'h1234_5679; m1_lock = 1'b0;
        #1;
        chk("lk_wr_m1_gnt", 32'(m1_gnt), 32'd1);
        chk("lk_wr_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("lk_wr_mem_we", 32'(mem_we), 32'd1);
        chk("lk_m1_rvalid_after", 32'(m1_rvalid), 32'd0);
        tick;
        m1_req = 1'b0; m1_we = 1'b0; m0_addr = 32'h20;
        #1;
        chk("unlk_m0_gnt", 32'(m0_gnt), 32'd1);
        chk("unlk_mem_addr", mem_addr, 32'h20);
        tick;
        #1;
        chk("unlk_m0_rvalid", 32'(m0_rvalid), 32'd1);
        chk("unlk_m0_rdata", m0_rdata, 32'h1234_5679);

        // Reset mid-read while LOCKED
        m0_req = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10; m1_lock = 1'b1;
        #1;
        chk("rmr_m1_gnt_a", 32'(m1_gnt), 32'd1);
        tick;
        m0_req = 1'b1;
        #1;
        chk("rmr_m0_gnt_locked", 32'(m0_gnt), 32'd0);
        chk("rmr_m1_gnt_b", 32'(m1_gnt), 32'd1);
        chk("rmr_m1_rvalid_a", 32'(m1_rvalid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rmr_m1_gnt_rst", 32'(m1_gnt), 32'd0);
        chk("rmr_m1_rvalid_rst", 32'(m1_rvalid), 32'd0);
        tick;
        rst_n = 1'b1; m1_req = 1'b0;
        #1;
        chk("rmr_m1_rvalid_after", 32'(m1_rvalid), 32'd0);
        chk("rmr_m0_gnt_unlocked", 32'(m0_gnt), 32'd1);
        chk("rmr_starve", 32'(dut.starve_cnt_r), 32'd0);
        tick;
        #1;
        chk("rmr_m1_rvalid_late", 32'(m1_rvalid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
